// File: rtl/cmd_buffer_mw.sv
// Command buffer for the GP engine: a DEPTH-word store written and read through the
// AHB slave path, plus a sequenced multi-word fetch that hands whole commands to the engine FSM.
module cmd_buffer_mw #(
    parameter int DATA_WIDTH       = 32,
    parameter int DEPTH            = 256,
    parameter int CMD_WORDS        = 2,
    parameter int TRANS_ADDR_WIDTH = $clog2(DEPTH),
    parameter int IDX_WIDTH        = TRANS_ADDR_WIDTH - $clog2(CMD_WORDS)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cmd_rd_en,
    input  logic [IDX_WIDTH-1:0]            cmd_idx,
    output logic                            cmd_rd_valid,
    output logic [CMD_WORDS*DATA_WIDTH-1:0] cmd_out,
    output logic                            cmd_busy,
    input  logic                            cmd_en,
    input  logic [TRANS_ADDR_WIDTH-1:0]     trans_addr,
    input  logic                            buf_lock,
    input  logic                            slv_o_valid,
    input  logic [DATA_WIDTH-1:0]           slv_o_wr_data,
    input  logic                            slv_o_rd0_wr1,
    output logic                            slv_i_ready,
    output logic [DATA_WIDTH-1:0]           slv_i_rd_data,
    output logic                            slv_i_rd_valid,
    output logic                            slv_o_wr_err
);

    localparam int K_WIDTH    = (CMD_WORDS > 1) ? $clog2(CMD_WORDS) : 1;
    localparam int WORD_SHIFT = $clog2(CMD_WORDS);
    localparam logic [K_WIDTH-1:0] K_LAST = K_WIDTH'(CMD_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DONE
    } state_t;

    state_t                      state;
    state_t                      state_next;
    logic [DATA_WIDTH-1:0]       mem [DEPTH];
    logic [TRANS_ADDR_WIDTH-1:0] base;
    logic [TRANS_ADDR_WIDTH-1:0] fetch_addr;
    logic [K_WIDTH-1:0]          k;
    logic                        accept;
    logic                        wr_accept;
    logic                        rd_accept;

    assign accept     = slv_o_valid && cmd_en && slv_i_ready;
    assign wr_accept  = accept && slv_o_rd0_wr1;
    assign rd_accept  = accept && !slv_o_rd0_wr1;
    assign fetch_addr = base + TRANS_ADDR_WIDTH'(k);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_rd_en) state_next = FETCH;
            FETCH:   if (k == K_LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Slave access is only granted while the fetcher is idle and not about to start,
    // which keeps every fetched command coherent.
    always_comb begin
        cmd_busy     = (state != IDLE);
        cmd_rd_valid = (state == DONE);
        slv_i_ready  = (state == IDLE) && !cmd_rd_en;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base    <= '0;
            k       <= '0;
            cmd_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_rd_en) begin
                        base <= TRANS_ADDR_WIDTH'(cmd_idx) << WORD_SHIFT;
                        k    <= '0;
                    end
                end
                FETCH: begin
                    cmd_out[32'(k) * DATA_WIDTH +: DATA_WIDTH] <= mem[fetch_addr];
                    k <= k + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Read data is forced to zero outside its valid pulse so the bus never sees stale words.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            slv_i_rd_data  <= '0;
            slv_i_rd_valid <= 1'b0;
            slv_o_wr_err   <= 1'b0;
        end else begin
            if (wr_accept && !buf_lock) begin
                mem[trans_addr] <= slv_o_wr_data;
            end
            slv_i_rd_valid <= rd_accept;
            slv_i_rd_data  <= rd_accept ? mem[trans_addr] : '0;
            slv_o_wr_err   <= wr_accept && buf_lock;
        end
    end

endmodule
